// File: rtl/if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: PC, IMEM addressing, redirects.
// Define IF_DELAY_SLOT_EN to keep the delay-slot fetch instead of squashing it on a redirect.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [2:0]  pc_mux_select,
  input  logic [31:0] rs_data,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  typedef enum logic [2:0] {
    SEL_J   = 3'b000,
    SEL_JR  = 3'b001,
    SEL_SEQ = 3'b010,
    SEL_BR  = 3'b100
  } pc_sel_e;

  logic [31:0] pc_q,      pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q,   id_pc_d;
  logic [31:0] id_pc4_q,  id_pc4_d;
  logic        id_valid_q, id_valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] target;
  logic        redirect;

  // Target is computed from the instruction held in ID, not the word being fetched.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pc_plus4  = pc_q + 32'd4;
    br_offset = {{14{id_inst_q[15]}}, id_inst_q[15:0], 2'b00};
    target    = pc_plus4;
    redirect  = 1'b0;
    case (pc_mux_select)
      SEL_J: begin
        target   = {id_pc4_q[31:28], id_inst_q[25:0], 2'b00};
        redirect = id_valid_q;
      end
      SEL_JR: begin
        target   = rs_data;
        redirect = id_valid_q;
      end
      SEL_BR: begin
        target   = id_pc4_q + br_offset;
        redirect = id_valid_q;
      end
      default: begin
        target   = pc_plus4;
        redirect = 1'b0;
      end
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    // A stall holds everything; a pending redirect is re-evaluated once it drops.
    if (!stall) begin
      id_pc_d  = pc_q;
      id_pc4_d = pc_plus4;
      if (redirect) begin
        pc_d = target;
`ifdef IF_DELAY_SLOT_EN
        id_inst_d  = imem_rdata;
        id_valid_d = 1'b1;
`else
        id_inst_d  = NOP_INST;
        id_valid_d = 1'b0;
`endif
      end else begin
        pc_d       = pc_plus4;
        id_inst_d  = imem_rdata;
        id_valid_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= 32'd0;
      id_pc4_q   <= 32'd0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign id_inst   = id_inst_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc4_q;
  assign id_valid  = id_valid_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboarded directed bench for if_id_stage; expectations cover both IF_DELAY_SLOT_EN builds.
module tb_if_id_stage;

`ifdef IF_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] idpc;
    logic [31:0] idpc4;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [2:0]  pc_mux_select;
  logic [31:0] rs_data, imem_addr, imem_rdata, pc, id_inst, id_pc, id_pc4;
  logic        id_valid;
  logic        use_word;
  logic [31:0] word;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  // IMEM returns a fixed pattern unless the stimulus forces a specific instruction word.
  assign imem_rdata = use_word ? word : (imem_addr ^ 32'hA5A5_0000);

  if_id_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .pc_mux_select (pc_mux_select),
    .rs_data       (rs_data),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
    .id_pc4        (id_pc4),
    .id_valid      (id_valid)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; the expectation is the state after the following rising edge.
  task automatic step(input string tag, input logic r, input logic s, input logic [2:0] sel,
                      input logic [31:0] rs, input logic uw, input logic [31:0] w,
                      input logic [31:0] e_pc, input logic [31:0] e_inst,
                      input logic [31:0] e_idpc, input logic [31:0] e_idpc4, input logic e_v);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; pc_mux_select = sel; rs_data = rs; use_word = uw; word = w;
    e.tag = tag; e.pc = e_pc; e.inst = e_inst; e.idpc = e_idpc; e.idpc4 = e_idpc4; e.valid = e_v;
    sb.push_back(e);
  endtask

  // Monitor: the DUT presents a new IF/ID state every cycle.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".pc"},        pc,        e.pc);
        check({e.tag, ".imem_addr"}, imem_addr, e.pc);
        check({e.tag, ".id_inst"},   id_inst,   e.inst);
        check({e.tag, ".id_pc"},     id_pc,     e.idpc);
        check({e.tag, ".id_pc4"},    id_pc4,    e.idpc4);
        check({e.tag, ".id_valid"},  {31'd0, id_valid}, {31'd0, e.valid});
      end
    end
  end

  localparam logic [2:0] SQ = 3'b010, J = 3'b000, JR = 3'b001, BR = 3'b100;
  localparam logic [31:0] BEQ_F = 32'h1000_0003, J_W = 32'h0810_0040, BEQ_B = 32'h1000_FFFF;

  initial begin
    logic [31:0] rd_inst;
    rst = 1'b1; stall = 1'b0; pc_mux_select = SQ; rs_data = '0; use_word = 1'b0; word = '0;

    // Reset and sequential fetch
    step("rst0", 1, 0, SQ, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
    step("rst1", 1, 0, SQ, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
    step("seq0", 0, 0, SQ, 0, 0, 0, 32'h0040_0004, pat(32'h0040_0000), 32'h0040_0000, 32'h0040_0004, 1);
    step("seq1", 0, 0, SQ, 0, 0, 0, 32'h0040_0008, pat(32'h0040_0004), 32'h0040_0004, 32'h0040_0008, 1);
    step("seq2", 0, 0, SQ, 0, 0, 0, 32'h0040_000C, pat(32'h0040_0008), 32'h0040_0008, 32'h0040_000C, 1);
    step("seq3", 0, 0, SQ, 0, 0, 0, 32'h0040_0010, pat(32'h0040_000C), 32'h0040_000C, 32'h0040_0010, 1);
    step("beq_f", 0, 0, SQ, 0, 1, BEQ_F, 32'h0040_0014, BEQ_F, 32'h0040_0010, 32'h0040_0014, 1);

    // Stall over a taken branch: nothing moves
    for (int i = 0; i < 3; i++)
      step("stall", 0, 1, BR, 0, 0, 0, 32'h0040_0014, BEQ_F, 32'h0040_0010, 32'h0040_0014, 1);

    // Forward branch taken once the stall releases
    rd_inst = DS ? pat(32'h0040_0014) : 32'h0;
    step("br_f", 0, 0, BR, 0, 0, 0, 32'h0040_0020, rd_inst, 32'h0040_0014, 32'h0040_0018, DS);
    // J select while the bubble sits in ID must be ignored
    step("post_br", 0, 0, DS ? SQ : J, 0, 0, 0, 32'h0040_0024, pat(32'h0040_0020), 32'h0040_0020, 32'h0040_0024, 1);

    // Reset mid-operation with a branch select and stall pending
    step("rst_mid", 1, 1, BR, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
    step("j_a", 0, 0, SQ, 0, 0, 0, 32'h0040_0004, pat(32'h0040_0000), 32'h0040_0000, 32'h0040_0004, 1);
    step("j_b", 0, 0, SQ, 0, 1, J_W, 32'h0040_0008, J_W, 32'h0040_0004, 32'h0040_0008, 1);
    rd_inst = DS ? pat(32'h0040_0008) : 32'h0;
    step("j", 0, 0, J, 0, 0, 0, 32'h0040_0100, rd_inst, 32'h0040_0008, 32'h0040_000C, DS);
    // Unassigned select 3'b111 acts as sequential
    step("sel111", 0, 0, 3'b111, 0, 0, 0, 32'h0040_0104, pat(32'h0040_0100), 32'h0040_0100, 32'h0040_0104, 1);
    rd_inst = DS ? pat(32'h0040_0104) : 32'h0;
    step("jr", 0, 0, JR, 32'h0040_0200, 0, 0, 32'h0040_0200, rd_inst, 32'h0040_0104, 32'h0040_0108, DS);
    step("post_jr", 0, 0, SQ, 0, 0, 0, 32'h0040_0204, pat(32'h0040_0200), 32'h0040_0200, 32'h0040_0204, 1);

    // Backward branch with imm16 = -1
    step("rst_b", 1, 0, SQ, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
    step("bb_a", 0, 0, SQ, 0, 0, 0, 32'h0040_0004, pat(32'h0040_0000), 32'h0040_0000, 32'h0040_0004, 1);
    step("bb_b", 0, 0, SQ, 0, 1, BEQ_B, 32'h0040_0008, BEQ_B, 32'h0040_0004, 32'h0040_0008, 1);
    rd_inst = DS ? pat(32'h0040_0008) : 32'h0;
    step("br_b", 0, 0, BR, 0, 0, 0, 32'h0040_0004, rd_inst, 32'h0040_0008, 32'h0040_000C, DS);
    step("post_bb", 0, 0, SQ, 0, 0, 0, 32'h0040_0008, pat(32'h0040_0004), 32'h0040_0004, 32'h0040_0008, 1);

    // PC wrap: JR to the last word, then fetch sequentially through zero
    rd_inst = DS ? pat(32'h0040_0008) : 32'h0;
    step("jr_top", 0, 0, JR, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, rd_inst, 32'h0040_0008, 32'h0040_000C, DS);
    step("wrap0", 0, 0, SQ, 0, 0, 0, 32'h0000_0000, 32'h5A5A_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1);
    step("wrap1", 0, 0, SQ, 0, 0, 0, 32'h0000_0004, 32'hA5A5_0000, 32'h0000_0000, 32'h0000_0004, 1);

    stim_done = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #5;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
